// File: rtl/bus_owner_arbiter.sv
// Round-robin owner arbiter for the shared datapath bus.
// Grants one source at a time, limits how long an owner may hold the bus
// unless locked, and counts cycles where several sources want the bus.
module bus_owner_arbiter #(
  parameter int NUM_REQ  = 24,
  parameter int SEL_W    = 5,
  parameter int MAX_HOLD = 16,
  parameter int IDLE_SEL = 31
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [NUM_REQ-1:0] req,
  input  logic               lock,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               preempt,
  output logic [7:0]         conflict_cnt
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t             r_state;
  logic [SEL_W-1:0]   r_ptr;
  logic [HOLD_W-1:0]  r_holdCnt;
  logic [NUM_REQ-1:0] r_grant;
  logic [SEL_W-1:0]   r_sel;
  logic               r_preempt;
  logic [7:0]         r_conflictCnt;

  state_t             w_stateNext;
  logic [SEL_W-1:0]   w_ptrNext;
  logic [HOLD_W-1:0]  w_holdNext;
  logic [NUM_REQ-1:0] w_grantNext;
  logic [SEL_W-1:0]   w_selNext;
  logic               w_preemptNext;
  logic [NUM_REQ-1:0] w_cand;
  logic               w_found;
  logic [SEL_W-1:0]   w_winner;
  logic [SEL_W-1:0]   w_winnerPtr;
  logic [SEL_W:0]     w_idx;
  logic               w_ownerReq;
  logic               w_multiReq;

  // Round-robin search from the pointer over every requester except the current owner
  always_comb begin
    w_cand   = req & ~r_grant;
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + (SEL_W + 1)'(k);
      if (w_idx >= (SEL_W + 1)'(NUM_REQ)) begin
        w_idx = w_idx - (SEL_W + 1)'(NUM_REQ);
      end
      if (!w_found && w_cand[w_idx[SEL_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[SEL_W-1:0];
      end
    end
    w_winnerPtr = (w_winner == SEL_W'(NUM_REQ - 1)) ? '0 : w_winner + SEL_W'(1);
    w_ownerReq  = |(req & r_grant);
    w_multiReq  = (req & (req - NUM_REQ'(1))) != '0;
  end

  // Next-state and next-output decisions for the ownership FSM
  always_comb begin
    w_stateNext   = r_state;
    w_ptrNext     = r_ptr;
    w_holdNext    = r_holdCnt;
    w_grantNext   = r_grant;
    w_selNext     = r_sel;
    w_preemptNext = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_stateNext = OWNED;
          w_grantNext = NUM_REQ'(1) << w_winner;
          w_selNext   = w_winner;
          w_holdNext  = HOLD_W'(1);
          w_ptrNext   = w_winnerPtr;
        end
      end
      OWNED: begin
        if (w_ownerReq) begin
          if (r_holdCnt == HOLD_W'(MAX_HOLD) && !lock && w_found) begin
            w_grantNext   = NUM_REQ'(1) << w_winner;
            w_selNext     = w_winner;
            w_holdNext    = HOLD_W'(1);
            w_ptrNext     = w_winnerPtr;
            w_preemptNext = 1'b1;
          end else if (r_holdCnt < HOLD_W'(MAX_HOLD)) begin
            w_holdNext = r_holdCnt + HOLD_W'(1);
          end
        end else if (w_found) begin
          w_grantNext = NUM_REQ'(1) << w_winner;
          w_selNext   = w_winner;
          w_holdNext  = HOLD_W'(1);
          w_ptrNext   = w_winnerPtr;
        end else begin
          w_stateNext = IDLE;
          w_grantNext = '0;
          w_selNext   = SEL_W'(IDLE_SEL);
          w_holdNext  = '0;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State register with synchronous clear; conflict counter saturates at 255
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_holdCnt     <= '0;
      r_grant       <= '0;
      r_sel         <= SEL_W'(IDLE_SEL);
      r_preempt     <= 1'b0;
      r_conflictCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_ptr     <= w_ptrNext;
      r_holdCnt <= w_holdNext;
      r_grant   <= w_grantNext;
      r_sel     <= w_selNext;
      r_preempt <= w_preemptNext;
      if (w_multiReq && r_conflictCnt != 8'hFF) begin
        r_conflictCnt <= r_conflictCnt + 8'd1;
      end
    end
  end

  assign grant        = r_grant;
  assign sel          = r_sel;
  assign busy         = (r_state == OWNED);
  assign preempt      = r_preempt;
  assign conflict_cnt = r_conflictCnt;

endmodule

// File: tb/tb_bus_owner_arbiter.sv
// Self-checking bench for bus_owner_arbiter: directed scenarios plus random
// traffic, compared every cycle against an ownership model kept here.
module tb_bus_owner_arbiter;

  localparam int N        = 24;
  localparam int MAXH     = 16;
  localparam int IDLE_SEL = 31;

  logic          clock = 1'b0;
  logic          clear = 1'b1;
  logic [N-1:0]  req   = '0;
  logic          lock  = 1'b0;
  logic [N-1:0]  grant;
  logic [4:0]    sel;
  logic          busy;
  logic          preempt;
  logic [7:0]    conflict_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: owner index or -1, pointer, hold cycles, pulse, conflicts
  int mOwner   = -1;
  int mPtr     = 0;
  int mHold    = 0;
  int mPreempt = 0;
  int mConf    = 0;
  bit modelValid = 1'b0;

  bus_owner_arbiter #(
    .NUM_REQ(N), .SEL_W(5), .MAX_HOLD(MAXH), .IDLE_SEL(IDLE_SEL)
  ) dut (
    .clock(clock), .clear(clear), .req(req), .lock(lock),
    .grant(grant), .sel(sel), .busy(busy), .preempt(preempt),
    .conflict_cnt(conflict_cnt)
  );

  // Free-running clock
  always #5 clock = ~clock;

  // Single comparison: counts it and reports a mismatch
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // First requesting index at or after start (wrapping), skipping excl
  function automatic int rrPick(input logic [N-1:0] mask, input int start, input int excl);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (mask[i] && i != excl) return i;
    end
    return -1;
  endfunction

  // Reference model advances on each rising edge from the sampled inputs
  always @(posedge clock) begin
    int w;
    if (clear) begin
      mOwner = -1; mPtr = 0; mHold = 0; mPreempt = 0; mConf = 0;
      modelValid = 1'b1;
    end else begin
      if ($countones(req) >= 2 && mConf < 255) mConf++;
      mPreempt = 0;
      if (mOwner < 0) begin
        w = rrPick(req, mPtr, -1);
        if (w >= 0) begin
          mOwner = w; mHold = 1; mPtr = (w + 1) % N;
        end
      end else if (req[mOwner]) begin
        w = rrPick(req, mPtr, mOwner);
        if (mHold == MAXH && !lock && w >= 0) begin
          mOwner = w; mHold = 1; mPtr = (w + 1) % N; mPreempt = 1;
        end else if (mHold < MAXH) begin
          mHold++;
        end
      end else begin
        w = rrPick(req, mPtr, -1);
        if (w >= 0) begin
          mOwner = w; mHold = 1; mPtr = (w + 1) % N;
        end else begin
          mOwner = -1; mHold = 0;
        end
      end
    end
  end

  // Every cycle once the model is anchored by a clear, compare all outputs
  always @(negedge clock) begin
    if (modelValid) begin
      checkOutput("grant", int'(grant), (mOwner < 0) ? 0 : (1 << mOwner));
      checkOutput("sel", int'(sel), (mOwner < 0) ? IDLE_SEL : mOwner);
      checkOutput("busy", int'(busy), (mOwner < 0) ? 0 : 1);
      checkOutput("preempt", int'(preempt), mPreempt);
      checkOutput("conflict_cnt", int'(conflict_cnt), mConf);
    end
  end

  // Drive inputs just after a falling edge and let n cycles elapse
  task automatic applyStimulus(input logic [N-1:0] r, input logic l, input logic c, input int n);
    req = r; lock = l; clear = c;
    repeat (n) @(negedge clock);
    #1;
  endtask

  initial begin
    int seq[$];
    int lastOwner;
    logic [N-1:0] pend;
    bit readd;

    // Reset state
    applyStimulus('0, 1'b0, 1'b1, 2);
    checkOutput("rst_sel", int'(sel), 31);
    checkOutput("rst_grant", int'(grant), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_conf", int'(conflict_cnt), 0);

    // Single PC request
    applyStimulus(N'(1) << 20, 1'b0, 1'b0, 1);
    checkOutput("pc_sel", int'(sel), 20);
    checkOutput("pc_grant", int'(grant), 32'h100000);
    checkOutput("pc_busy", int'(busy), 1);
    checkOutput("pc_model_owner", mOwner, 20);
    applyStimulus(N'(1) << 20, 1'b0, 1'b0, 3);
    applyStimulus('0, 1'b0, 1'b0, 1);
    checkOutput("pc_release_sel", int'(sel), 31);
    checkOutput("pc_release_busy", int'(busy), 0);

    // Round robin with back-to-back handover and pointer wrap
    applyStimulus('0, 1'b0, 1'b1, 1);
    pend = N'(1) | (N'(1) << 5) | (N'(1) << 23);
    readd = 1'b0;
    lastOwner = -1;
    for (int c = 0; c < 20 && pend != '0; c++) begin
      applyStimulus(pend, 1'b0, 1'b0, 1);
      if (mOwner >= 0 && mOwner != lastOwner) seq.push_back(mOwner);
      lastOwner = mOwner;
      if (mOwner >= 0) begin
        pend[mOwner] = 1'b0;
        if (mOwner == 23 && !readd) begin
          pend[0] = 1'b1;
          readd = 1'b1;
        end
      end
    end
    checkOutput("rr_count", seq.size(), 4);
    if (seq.size() == 4) begin
      checkOutput("rr_0", seq[0], 0);
      checkOutput("rr_1", seq[1], 5);
      checkOutput("rr_2", seq[2], 23);
      checkOutput("rr_3", seq[3], 0);
    end
    checkOutput("rr_ptr", mPtr, 1);

    // Preemption after MAX_HOLD cycles
    applyStimulus('0, 1'b0, 1'b1, 1);
    applyStimulus(N'(1) << 3, 1'b0, 1'b0, 1);
    checkOutput("pre_first", int'(sel), 3);
    applyStimulus((N'(1) << 3) | (N'(1) << 7), 1'b0, 1'b0, 15);
    checkOutput("pre_hold_sel", int'(sel), 3);
    checkOutput("pre_hold_pulse", int'(preempt), 0);
    applyStimulus((N'(1) << 3) | (N'(1) << 7), 1'b0, 1'b0, 1);
    checkOutput("pre_switch_sel", int'(sel), 7);
    checkOutput("pre_switch_pulse", int'(preempt), 1);
    checkOutput("pre_conf", int'(conflict_cnt), 16);
    applyStimulus((N'(1) << 3) | (N'(1) << 7), 1'b0, 1'b0, 1);
    checkOutput("pre_pulse_end", int'(preempt), 0);

    // Lock keeps R3 as owner; releasing it hands over at once
    applyStimulus('0, 1'b0, 1'b1, 1);
    applyStimulus(N'(1) << 3, 1'b1, 1'b0, 1);
    applyStimulus((N'(1) << 3) | (N'(1) << 7), 1'b1, 1'b0, 40);
    checkOutput("lock_sel", int'(sel), 3);
    applyStimulus((N'(1) << 3) | (N'(1) << 7), 1'b0, 1'b0, 1);
    checkOutput("unlock_sel", int'(sel), 7);
    checkOutput("unlock_pulse", int'(preempt), 1);

    // Conflict counter saturation with all sources requesting
    applyStimulus('0, 1'b0, 1'b1, 1);
    applyStimulus({N{1'b1}}, 1'b0, 1'b0, 300);
    checkOutput("sat_conf", int'(conflict_cnt), 255);

    // Clear while MDR owns the bus
    applyStimulus('0, 1'b0, 1'b1, 1);
    applyStimulus(N'(1) << 21, 1'b0, 1'b0, 3);
    checkOutput("mdr_sel", int'(sel), 21);
    applyStimulus(N'(1) << 21, 1'b0, 1'b1, 1);
    checkOutput("mdr_clr_sel", int'(sel), 31);
    checkOutput("mdr_clr_grant", int'(grant), 0);
    checkOutput("mdr_clr_ptr", mPtr, 0);
    applyStimulus(N'(1) << 21, 1'b0, 1'b0, 1);
    checkOutput("mdr_regrant", int'(sel), 21);

    // Random traffic: sparse requests, occasional lock and clear
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] r;
      r = '0;
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) r[b] = 1'b1;
      if ($urandom_range(0, 3) == 0) r = '0;
      applyStimulus(r, ($urandom_range(0, 5) == 0), ($urandom_range(0, 150) == 0),
                    $urandom_range(1, 20));
    end

    applyStimulus('0, 1'b0, 1'b0, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
